key_debounce: RTL and testbench

//  Debounces one mechanical push-button and turns it into clean, single-cycle event pulses.
//  One instance sits in front of the IIC controller for each key (write key, read key).
//  key_flag is the controller's start strobe; key_state, key_rel and key_long are spare

---
 rtl/key_pkg.sv | 14 +
 rtl/key_debounce.sv | 142 ++++++++++++++
 tb/tb_key_debounce.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared constants for the push-button debouncer: FSM state encoding and the
// system clock frequency the cycle-count defaults are derived from.
package key_pkg;

    localparam int CLK_FREQ = 50_000_000;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_FILT = 2'd1,
        DOWN       = 2'd2,
        REL_FILT   = 2'd3
    } db_state_e;

endpackage

// File: rtl/key_debounce.sv
// Push-button debouncer: synchronises the raw pin, filters bounce on both edges
// and emits registered single-cycle press / release / long-press pulses plus
// the debounced level.
module key_debounce
    import key_pkg::*;
#(
    parameter int DB_CYCLES      = CLK_FREQ / 50,   // 20 ms
    parameter int LONG_CYCLES    = CLK_FREQ,        // 1 s
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_flag,
    output logic key_rel,
    output logic key_long,
    output logic key_state
);

    localparam int FCNT_W = $clog2(DB_CYCLES);
    localparam int HCNT_W = $clog2(LONG_CYCLES);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(DB_CYCLES - 1);
    localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(LONG_CYCLES - 1);
    // Pin level of a released key; the synchroniser powers up here so reset
    // never looks like a press.
    localparam logic IDLE_LVL = KEY_ACTIVE_LOW;

    logic              sync_q1, sync_q2;
    logic              pressed;

    db_state_e         state, state_n;
    logic [FCNT_W-1:0] fcnt, fcnt_n;
    logic [HCNT_W-1:0] hcnt, hcnt_n;
    logic              long_done, long_done_n;
    logic              flag_n, rel_n, long_n, level_n;

    // Two-flop synchroniser for the asynchronous pin.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours, which is what makes the chain a pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= IDLE_LVL;
            sync_q2 <= IDLE_LVL;
        end else begin
            sync_q1 <= key_in;
            sync_q2 <= sync_q1;
        end
    end

    assign pressed = KEY_ACTIVE_LOW ? ~sync_q2 : sync_q2;

    // State, counters and registered pulse outputs.
    // NOTE: every flop here has an async reset value; there is no memory array,
    // so nothing is left un-reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            fcnt      <= '0;
            hcnt      <= '0;
            long_done <= 1'b0;
            key_flag  <= 1'b0;
            key_rel   <= 1'b0;
            key_long  <= 1'b0;
            key_state <= 1'b0;
        end else begin
            state     <= state_n;
            fcnt      <= fcnt_n;
            hcnt      <= hcnt_n;
            long_done <= long_done_n;
            key_flag  <= flag_n;
            key_rel   <= rel_n;
            key_long  <= long_n;
            key_state <= level_n;
        end
    end

    // Next-state, counter updates and pulse decisions.
    // NOTE: every variable gets a default first so no path through the case
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n     = state;
        fcnt_n      = fcnt;
        hcnt_n      = hcnt;
        long_done_n = long_done;
        flag_n      = 1'b0;
        rel_n       = 1'b0;
        long_n      = 1'b0;
        level_n     = key_state;

        unique case (state)
            IDLE: begin
                fcnt_n = '0;
                if (pressed) state_n = PRESS_FILT;
            end

            PRESS_FILT: begin
                if (!pressed) begin
                    state_n = IDLE;
                    fcnt_n  = '0;
                end else if (fcnt == FCNT_LAST) begin
                    state_n     = DOWN;
                    flag_n      = 1'b1;
                    level_n     = 1'b1;
                    hcnt_n      = '0;
                    long_done_n = 1'b0;
                end else begin
                    fcnt_n = fcnt + 1'b1;
                end
            end

            DOWN: begin
                if (hcnt < HCNT_LAST) hcnt_n = hcnt + 1'b1;
                // A release sample takes priority; an expiry that coincides
                // with it is reported on return from REL_FILT instead.
                if (!pressed) begin
                    state_n = REL_FILT;
                    fcnt_n  = '0;
                end else if (hcnt == HCNT_LAST && !long_done) begin
                    long_n      = 1'b1;
                    long_done_n = 1'b1;
                end
            end

            REL_FILT: begin
                // hcnt is frozen here so a release bounce does not lose the hold.
                if (pressed) begin
                    state_n = DOWN;
                end else if (fcnt == FCNT_LAST) begin
                    state_n = IDLE;
                    rel_n   = 1'b1;
                    level_n = 1'b0;
                    fcnt_n  = '0;
                end else begin
                    fcnt_n = fcnt + 1'b1;
                end
            end

            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce (DB_CYCLES=4, LONG_CYCLES=20).
// Expected pulses are queued with their due cycle when stimulus is driven and
// matched against observed pulses on the falling clock edge.
module tb_key_debounce;

    typedef enum int {EV_FLAG, EV_REL, EV_LONG} ev_kind_e;

    typedef struct {
        int       dut;
        ev_kind_e kind;
        int       cyc;
    } ev_t;

    // One clean press of length press_len followed by gap_len released cycles.
    // Offsets are relative to the cycle the press is driven; -1 = no pulse.
    typedef struct {
        int press_len;
        int gap_len;
        int flag_at;
        int long_at;
        int rel_at;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_lo = 1'b1;   // active-low instance, released = 1
    logic key_hi = 1'b0;   // active-high instance, released = 0

    logic lo_flag, lo_rel, lo_long, lo_state;
    logic hi_flag, hi_rel, hi_long, hi_state;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic prev_lo = 1'b0;
    logic prev_hi = 1'b0;
    ev_t  exp_q[$];

    key_debounce #(.DB_CYCLES(4), .LONG_CYCLES(20), .KEY_ACTIVE_LOW(1'b1)) dut_lo (
        .clk(clk), .rst(rst), .key_in(key_lo),
        .key_flag(lo_flag), .key_rel(lo_rel), .key_long(lo_long), .key_state(lo_state)
    );

    key_debounce #(.DB_CYCLES(4), .LONG_CYCLES(20), .KEY_ACTIVE_LOW(1'b0)) dut_hi (
        .clk(clk), .rst(rst), .key_in(key_hi),
        .key_flag(hi_flag), .key_rel(hi_rel), .key_long(hi_long), .key_state(hi_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input string detail);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    task automatic expect_ev(input int dut, input ev_kind_e kind, input int at);
        ev_t e;
        e.dut  = dut;
        e.kind = kind;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int dut, input ev_kind_e kind,
                           input logic st_now, input logic st_prev);
        ev_t e;
        if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_pulse",
                  $sformatf("got dut%0d %s at cycle %0d, want none", dut, kind.name(), cyc));
        end else begin
            e = exp_q.pop_front();
            check(e.dut == dut && e.kind == kind && e.cyc == cyc, "pulse",
                  $sformatf("got dut%0d %s at cycle %0d, want dut%0d %s at cycle %0d",
                            dut, kind.name(), cyc, e.dut, e.kind.name(), e.cyc));
        end
        case (kind)
            EV_FLAG: check(st_now && !st_prev, "state_rise_with_flag",
                           $sformatf("got state %0b->%0b, want 0->1", st_prev, st_now));
            EV_REL:  check(!st_now && st_prev, "state_fall_with_rel",
                           $sformatf("got state %0b->%0b, want 1->0", st_prev, st_now));
            default: check(st_now, "state_high_with_long",
                           $sformatf("got state %0b, want 1", st_now));
        endcase
    endtask

    task automatic monitor_one(input int dut, input logic f, input logic r, input logic l,
                               input logic st_now, input logic st_prev);
        int n;
        n = int'(f) + int'(r) + int'(l);
        if (n > 0)
            check(n == 1, "pulses_exclusive",
                  $sformatf("dut%0d got %0d pulses in cycle %0d, want at most 1", dut, n, cyc));
        if (f) observe(dut, EV_FLAG, st_now, st_prev);
        if (r) observe(dut, EV_REL,  st_now, st_prev);
        if (l) observe(dut, EV_LONG, st_now, st_prev);
    endtask

    // Advance to the next falling edge and score whatever the DUTs produced.
    task automatic tick();
        @(negedge clk);
        if (rst) begin
            prev_lo = 1'b0;
            prev_hi = 1'b0;
        end else begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                check(1'b0, "missed_pulse",
                      $sformatf("got nothing, want dut%0d %s at cycle %0d",
                                exp_q[0].dut, exp_q[0].kind.name(), exp_q[0].cyc));
                void'(exp_q.pop_front());
            end
            monitor_one(0, lo_flag, lo_rel, lo_long, lo_state, prev_lo);
            monitor_one(1, hi_flag, hi_rel, hi_long, hi_state, prev_hi);
            prev_lo = lo_state;
            prev_hi = hi_state;
        end
    endtask

    task automatic check_lo_zero(input string name);
        check({lo_flag, lo_rel, lo_long, lo_state} == 4'b0, name,
              $sformatf("got flag/rel/long/state=%0b%0b%0b%0b, want 0000",
                        lo_flag, lo_rel, lo_long, lo_state));
    endtask

    initial begin
        vec_t vecs[7];
        int   n;
        int   m;

        vecs[0] = '{press_len: 3,  gap_len: 10, flag_at: -1, long_at: -1, rel_at: -1};
        vecs[1] = '{press_len: 4,  gap_len: 10, flag_at: -1, long_at: -1, rel_at: -1};
        vecs[2] = '{press_len: 5,  gap_len: 10, flag_at: 7,  long_at: -1, rel_at: 12};
        vecs[3] = '{press_len: 10, gap_len: 10, flag_at: 7,  long_at: -1, rel_at: 17};
        vecs[4] = '{press_len: 24, gap_len: 10, flag_at: 7,  long_at: -1, rel_at: 31};
        vecs[5] = '{press_len: 25, gap_len: 10, flag_at: 7,  long_at: 27, rel_at: 32};
        vecs[6] = '{press_len: 30, gap_len: 10, flag_at: 7,  long_at: 27, rel_at: 37};

        // Reset state, asserted before any clock edge.
        #3;
        check_lo_zero("reset_lo");
        check({hi_flag, hi_rel, hi_long, hi_state} == 4'b0, "reset_hi",
              $sformatf("got flag/rel/long/state=%0b%0b%0b%0b, want 0000",
                        hi_flag, hi_rel, hi_long, hi_state));
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();
        check_lo_zero("idle_after_reset");

        // Table: single presses of varying length on the active-low key.
        foreach (vecs[i]) begin
            tick();
            n = cyc;
            key_lo = 1'b0;
            if (vecs[i].flag_at >= 0) expect_ev(0, EV_FLAG, n + vecs[i].flag_at);
            if (vecs[i].long_at >= 0) expect_ev(0, EV_LONG, n + vecs[i].long_at);
            repeat (vecs[i].press_len) tick();
            key_lo = 1'b1;
            if (vecs[i].rel_at >= 0) expect_ev(0, EV_REL, n + vecs[i].rel_at);
            repeat (vecs[i].gap_len) tick();
            check(lo_state == 1'b0, $sformatf("released_state_vec%0d", i),
                  $sformatf("got %0b, want 0", lo_state));
        end

        // Bounce: low 3, high 1, low 3, then high -> nothing.
        tick();
        key_lo = 1'b0;
        repeat (3) tick();
        key_lo = 1'b1;
        tick();
        key_lo = 1'b0;
        repeat (3) tick();
        check(lo_state == 1'b0, "bounce_state_mid", $sformatf("got %0b, want 0", lo_state));
        key_lo = 1'b1;
        repeat (10) tick();
        check(lo_state == 1'b0, "bounce_state_end", $sformatf("got %0b, want 0", lo_state));

        // Long hold with a 2-cycle release glitch: frozen hold counter delays
        // key_long by two cycles; no extra flag and no release.
        tick();
        n = cyc;
        key_lo = 1'b0;
        expect_ev(0, EV_FLAG, n + 7);
        expect_ev(0, EV_LONG, n + 29);
        repeat (12) tick();
        key_lo = 1'b1;
        repeat (2) tick();
        key_lo = 1'b0;
        repeat (21) tick();
        check(lo_state == 1'b1, "glitch_state_held", $sformatf("got %0b, want 1", lo_state));
        key_lo = 1'b1;
        expect_ev(0, EV_REL, n + 42);
        repeat (10) tick();

        // Reset mid-press with the key kept held: outputs drop at once, then a
        // fresh full filter window.
        tick();
        n = cyc;
        key_lo = 1'b0;
        expect_ev(0, EV_FLAG, n + 7);
        repeat (9) tick();
        check(lo_state == 1'b1, "state_before_rst", $sformatf("got %0b, want 1", lo_state));
        #2 rst = 1'b1;
        #1 check_lo_zero("async_reset_mid_press");
        repeat (2) tick();
        rst = 1'b0;
        m = cyc;
        expect_ev(0, EV_FLAG, m + 7);
        repeat (6) tick();
        check(lo_state == 1'b0, "state_before_reflag", $sformatf("got %0b, want 0", lo_state));
        repeat (6) tick();
        key_lo = 1'b1;
        expect_ev(0, EV_REL, cyc + 7);
        repeat (10) tick();

        // Active-high instance, same clean press as the first table entries.
        tick();
        n = cyc;
        key_hi = 1'b1;
        expect_ev(1, EV_FLAG, n + 7);
        repeat (10) tick();
        check(hi_state == 1'b1, "hi_state_pressed", $sformatf("got %0b, want 1", hi_state));
        key_hi = 1'b0;
        expect_ev(1, EV_REL, n + 17);
        repeat (10) tick();
        check(hi_state == 1'b0, "hi_state_released", $sformatf("got %0b, want 0", hi_state));

        repeat (5) tick();
        check(exp_q.size() == 0, "all_pulses_seen",
              $sformatf("got %0d outstanding, want 0", exp_q.size()));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
